// File: rtl/axi4_lite_bus_join_rd_if.sv
// AXI4-Lite read-channel bundle (AR + R) used for both upstream masters and the downstream slave.
// The master modport drives requests; the slave modport answers them.
interface axi4_lite_bus_join_rd_if #(
  parameter int A = 32,
  parameter int D = 32
);
  logic         arvalid;
  logic         arready;
  logic [A-1:0] araddr;
  logic [2:0]   arprot;
  logic         rvalid;
  logic         rready;
  logic [D-1:0] rdata;
  logic [1:0]   rresp;

  modport master (
    output arvalid, araddr, arprot, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, arprot, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_bus_join_rd.sv
// Two-master to one-slave AXI4-Lite read join: round-robin AR arbitration into a registered AR
// stage, with an in-order route FIFO steering each R beat back to the master that issued it.
module axi4_lite_bus_join_rd #(
  parameter int A     = 32,
  parameter int D     = 32,
  parameter int N_OUT = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  axi4_lite_bus_join_rd_if.slave  s0,
  axi4_lite_bus_join_rd_if.slave  s1,
  axi4_lite_bus_join_rd_if.master m
);
  localparam int            PW      = $clog2(N_OUT);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(N_OUT);

  logic          r_arvalid;
  logic [A-1:0]  r_araddr;
  logic [2:0]    r_arprot;
  logic          r_last_grant;
  logic [CW-1:0] r_count;
  logic [N_OUT-1:0] r_route;
  logic [PW:0]   r_wr_ptr;
  logic [PW:0]   r_rd_ptr;

  logic          w_fifo_empty;
  logic          w_head;
  logic          w_head_rready;
  logic          w_rready;
  logic          w_r_hs;
  logic          w_any;
  logic          w_grant;
  logic [CW-1:0] w_count_after;
  logic          w_load;

  // R path: head of the route FIFO picks the owning master, zero latency.
  always_comb begin
    w_fifo_empty  = (r_wr_ptr == r_rd_ptr);
    w_head        = r_route[r_rd_ptr[PW-1:0]];
    w_head_rready = w_head ? s1.rready : s0.rready;
    w_rready      = ~areset & ~w_fifo_empty & w_head_rready;
    w_r_hs        = m.rvalid & w_rready;
  end

  // A completing R frees a slot in the same cycle, so a full block can still accept.
  always_comb begin
    w_any         = s0.arvalid | s1.arvalid;
    w_grant       = (s0.arvalid & s1.arvalid) ? ~r_last_grant : s1.arvalid;
    w_count_after = r_count - {{(CW-1){1'b0}}, w_r_hs};
    w_load        = ~areset & (~r_arvalid | m.arready) & (w_count_after < MAX_CNT) & w_any;
  end

  assign s0.arready = w_load & ~w_grant;
  assign s1.arready = w_load & w_grant;

  assign s0.rvalid  = ~areset & m.rvalid & ~w_fifo_empty & ~w_head;
  assign s1.rvalid  = ~areset & m.rvalid & ~w_fifo_empty & w_head;
  assign s0.rdata   = m.rdata;
  assign s1.rdata   = m.rdata;
  assign s0.rresp   = m.rresp;
  assign s1.rresp   = m.rresp;

  assign m.rready   = w_rready;
  assign m.arvalid  = r_arvalid;
  assign m.araddr   = r_araddr;
  assign m.arprot   = r_arprot;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arprot     <= '0;
      r_last_grant <= 1'b1;
    end else if (w_load) begin
      r_arvalid    <= 1'b1;
      r_araddr     <= w_grant ? s1.araddr : s0.araddr;
      r_arprot     <= w_grant ? s1.arprot : s0.arprot;
      r_last_grant <= w_grant;
    end else if (m.arready) begin
      r_arvalid    <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_count <= '0;
    end else begin
      case ({w_load, w_r_hs})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_route  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_load) begin
        r_route[r_wr_ptr[PW-1:0]] <= w_grant;
        r_wr_ptr                  <= r_wr_ptr + 1'b1;
      end
      if (w_r_hs) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_bus_join_rd.sv
// Bench for the two-master AXI4-Lite read join: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural reference model.
module tb_axi4_lite_bus_join_rd;
  localparam int N_OUT = 4;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  axi4_lite_bus_join_rd_if #(.A(32), .D(32)) s0 ();
  axi4_lite_bus_join_rd_if #(.A(32), .D(32)) s1 ();
  axi4_lite_bus_join_rd_if #(.A(32), .D(32)) m ();

  axi4_lite_bus_join_rd #(.A(32), .D(32), .N_OUT(N_OUT)) dut (
    .aclk  (aclk),
    .areset(areset),
    .s0    (s0),
    .s1    (s1),
    .m     (m)
  );

  always #5 aclk = ~aclk;

  // reference model state
  bit          exp_mv;
  logic [31:0] exp_ma;
  logic [2:0]  exp_mp;
  bit          last;
  int          route[$];
  int          pending;
  bit exp_s0ar, exp_s1ar, exp_s0rv, exp_s1rv, exp_mrr, exp_hs, exp_load, g;

  task automatic model_reset();
    route.delete();
    exp_mv = 0; exp_ma = '0; exp_mp = '0; last = 1; pending = 0;
  endtask

  task automatic model_comb();
    bit empty, head_rdy;
    int cnt_after;
    empty     = (route.size() == 0);
    exp_s0rv  = !areset && m.rvalid && !empty && (empty ? 0 : route[0] == 0);
    exp_s1rv  = !areset && m.rvalid && !empty && (empty ? 0 : route[0] == 1);
    head_rdy  = empty ? 1'b0 : (route[0] == 0 ? s0.rready : s1.rready);
    exp_mrr   = !areset && !empty && head_rdy;
    exp_hs    = exp_mrr && m.rvalid;
    cnt_after = route.size() - (exp_hs ? 1 : 0);
    g         = (s0.arvalid && s1.arvalid) ? !last : s1.arvalid;
    exp_load  = !areset && (!exp_mv || m.arready) && (cnt_after < N_OUT) && (s0.arvalid || s1.arvalid);
    exp_s0ar  = exp_load && !g;
    exp_s1ar  = exp_load && g;
  endtask

  task automatic model_seq();
    if (areset) begin
      model_reset();
    end else begin
      if (exp_mv && m.arready) pending++;
      if (exp_hs) begin void'(route.pop_front()); pending--; end
      if (exp_load) begin
        route.push_back(int'(g));
        exp_mv = 1;
        exp_ma = g ? s1.araddr : s0.araddr;
        exp_mp = g ? s1.arprot : s0.arprot;
        last   = g;
      end else if (m.arready) begin
        exp_mv = 0;
      end
    end
  endtask

  task automatic tick();
    model_comb();
    @(posedge aclk);
    model_seq();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    s0.arvalid = 0; s0.araddr = '0; s0.arprot = '0; s0.rready = 0;
    s1.arvalid = 0; s1.araddr = '0; s1.arprot = '0; s1.rready = 0;
    m.arready = 0; m.rvalid = 0; m.rdata = '0; m.rresp = '0;
  endtask

  task automatic do_reset();
    areset = 1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge aclk);
    areset = 0;
  endtask

  task automatic test_reset();
    areset = 1;
    model_reset();
    idle_inputs();
    s0.arvalid = 1; s1.arvalid = 1; m.rvalid = 1; m.arready = 1; s0.rready = 1; s1.rready = 1;
    @(negedge aclk); #1;
    checks++; if (s0.arready !== 1'b0) $display("FAIL reset_s0_arready got=%b want=0", s0.arready); else passed++;
    checks++; if (s1.arready !== 1'b0) $display("FAIL reset_s1_arready got=%b want=0", s1.arready); else passed++;
    checks++; if (m.rready !== 1'b0) $display("FAIL reset_m_rready got=%b want=0", m.rready); else passed++;
    checks++; if (s0.rvalid !== 1'b0) $display("FAIL reset_s0_rvalid got=%b want=0", s0.rvalid); else passed++;
    checks++; if (s1.rvalid !== 1'b0) $display("FAIL reset_s1_rvalid got=%b want=0", s1.rvalid); else passed++;
    checks++; if (m.arvalid !== 1'b0) $display("FAIL reset_m_arvalid got=%b want=0", m.arvalid); else passed++;
    checks++; if (m.araddr !== 32'h0) $display("FAIL reset_m_araddr got=%h want=0", m.araddr); else passed++;
    checks++; if (m.arprot !== 3'h0) $display("FAIL reset_m_arprot got=%h want=0", m.arprot); else passed++;
    idle_inputs();
    @(negedge aclk);
    areset = 0;
    m.rvalid = 1; s0.rready = 1; s1.rready = 1;
    #1;
    checks++; if (m.rready !== 1'b0) $display("FAIL empty_fifo_m_rready got=%b want=0", m.rready); else passed++;
    checks++; if (s0.rvalid !== 1'b0) $display("FAIL empty_fifo_s0_rvalid got=%b want=0", s0.rvalid); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    s0.arvalid = 1; s0.araddr = 32'h10; s0.arprot = 3'b010; m.arready = 1;
    #1;
    checks++; if (s0.arready !== 1'b1) $display("FAIL single_s0_arready got=%b want=1", s0.arready); else passed++;
    checks++; if (s1.arready !== 1'b0) $display("FAIL single_s1_arready got=%b want=0", s1.arready); else passed++;
    tick();
    s0.arvalid = 0; s0.araddr = '0;
    #1;
    checks++; if (m.arvalid !== 1'b1) $display("FAIL single_m_arvalid got=%b want=1", m.arvalid); else passed++;
    checks++; if (m.araddr !== 32'h10) $display("FAIL single_m_araddr got=%h want=10", m.araddr); else passed++;
    checks++; if (m.arprot !== 3'b010) $display("FAIL single_m_arprot got=%h want=2", m.arprot); else passed++;
    tick();
    m.rvalid = 1; m.rdata = 32'hA5A5_0001; m.rresp = 2'b00; s0.rready = 1; s1.rready = 1;
    #1;
    checks++; if (s0.rvalid !== 1'b1) $display("FAIL single_s0_rvalid got=%b want=1", s0.rvalid); else passed++;
    checks++; if (s1.rvalid !== 1'b0) $display("FAIL single_s1_rvalid got=%b want=0", s1.rvalid); else passed++;
    checks++; if (s0.rdata !== 32'hA5A5_0001) $display("FAIL single_s0_rdata got=%h want=a5a50001", s0.rdata); else passed++;
    checks++; if (m.rready !== 1'b1) $display("FAIL single_m_rready got=%b want=1", m.rready); else passed++;
    tick();
    m.rvalid = 0;
    #1;
    checks++; if (m.arvalid !== 1'b0) $display("FAIL single_m_arvalid_drop got=%b want=0", m.arvalid); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_tie();
    logic [31:0] seq [4];
    seq[0] = 32'h100; seq[1] = 32'h200; seq[2] = 32'h100; seq[3] = 32'h200;
    do_reset();
    s0.arvalid = 1; s0.araddr = 32'h100; s1.arvalid = 1; s1.araddr = 32'h200; m.arready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (s0.arready !== ((i % 2) == 0)) $display("FAIL tie_s0_arready[%0d] got=%b want=%b", i, s0.arready, (i % 2) == 0); else passed++;
      checks++; if (s1.arready !== ((i % 2) == 1)) $display("FAIL tie_s1_arready[%0d] got=%b want=%b", i, s1.arready, (i % 2) == 1); else passed++;
      tick();
      #1;
      checks++; if (m.araddr !== seq[i]) $display("FAIL tie_m_araddr[%0d] got=%h want=%h", i, m.araddr, seq[i]); else passed++;
    end
    s0.arvalid = 0; s1.arvalid = 0;
    m.rvalid = 1; s0.rready = 1; s1.rready = 1;
    for (int i = 0; i < 4; i++) begin
      m.rdata = 32'(i + 1);
      #1;
      checks++; if (s0.rvalid !== ((i % 2) == 0)) $display("FAIL tie_s0_rvalid[%0d] got=%b want=%b", i, s0.rvalid, (i % 2) == 0); else passed++;
      checks++; if (s1.rvalid !== ((i % 2) == 1)) $display("FAIL tie_s1_rvalid[%0d] got=%b want=%b", i, s1.rvalid, (i % 2) == 1); else passed++;
      checks++; if (((i % 2) == 0 ? s0.rdata : s1.rdata) !== 32'(i + 1)) $display("FAIL tie_rdata[%0d] got=%h want=%h", i, ((i % 2) == 0 ? s0.rdata : s1.rdata), i + 1); else passed++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_outstanding_limit();
    int n_hs = 0;
    do_reset();
    m.arready = 1; s0.arvalid = 1;
    for (int i = 0; i < 6; i++) begin
      s0.araddr = 32'h1000 + 32'(i * 4);
      #1;
      model_comb();
      checks++; if (s0.arready !== exp_s0ar) $display("FAIL limit_s0_arready[%0d] got=%b want=%b", i, s0.arready, exp_s0ar); else passed++;
      if (s0.arready === 1'b1) n_hs++;
      tick();
    end
    checks++; if (n_hs != 4) $display("FAIL limit_handshakes got=%0d want=4", n_hs); else passed++;
    m.rvalid = 1; m.rdata = 32'h7777; s0.rready = 1;
    #1;
    checks++; if (s0.arready !== 1'b1) $display("FAIL limit_accept_on_r got=%b want=1", s0.arready); else passed++;
    checks++; if (m.rready !== 1'b1) $display("FAIL limit_m_rready got=%b want=1", m.rready); else passed++;
    tick();
    m.rvalid = 0;
    #1;
    checks++; if (s0.arready !== 1'b0) $display("FAIL limit_full_again got=%b want=0", s0.arready); else passed++;
    s0.arvalid = 0; m.rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (s0.rvalid !== 1'b1) $display("FAIL limit_drain_s0_rvalid[%0d] got=%b want=1", i, s0.rvalid); else passed++;
      tick();
    end
    #1;
    checks++; if (s0.rvalid !== 1'b0) $display("FAIL limit_drained got=%b want=0", s0.rvalid); else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    m.arready = 0; s0.arvalid = 1; s0.araddr = 32'h44; s0.arprot = 3'd5;
    #1;
    checks++; if (s0.arready !== 1'b1) $display("FAIL bp_s0_arready got=%b want=1", s0.arready); else passed++;
    tick();
    s0.arvalid = 0; s1.arvalid = 1; s1.araddr = 32'h88; s1.arprot = 3'd1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (m.arvalid !== 1'b1) $display("FAIL bp_hold_arvalid[%0d] got=%b want=1", i, m.arvalid); else passed++;
      checks++; if (m.araddr !== 32'h44) $display("FAIL bp_hold_araddr[%0d] got=%h want=44", i, m.araddr); else passed++;
      checks++; if (m.arprot !== 3'd5) $display("FAIL bp_hold_arprot[%0d] got=%h want=5", i, m.arprot); else passed++;
      checks++; if (s1.arready !== 1'b0) $display("FAIL bp_s1_blocked[%0d] got=%b want=0", i, s1.arready); else passed++;
      tick();
    end
    m.arready = 1;
    #1;
    checks++; if (s1.arready !== 1'b1) $display("FAIL bp_s1_accept got=%b want=1", s1.arready); else passed++;
    tick();
    s1.arvalid = 0;
    #1;
    checks++; if (m.araddr !== 32'h88) $display("FAIL bp_m_araddr got=%h want=88", m.araddr); else passed++;
    checks++; if (m.arprot !== 3'd1) $display("FAIL bp_m_arprot got=%h want=1", m.arprot); else passed++;
    tick();
    m.arready = 0; m.rvalid = 1; m.rdata = 32'h5; s0.rready = 1; s1.rready = 0;
    #1;
    checks++; if (s0.rvalid !== 1'b1) $display("FAIL bp_s0_rvalid got=%b want=1", s0.rvalid); else passed++;
    checks++; if (m.rready !== 1'b1) $display("FAIL bp_s0_m_rready got=%b want=1", m.rready); else passed++;
    tick();
    m.rdata = 32'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s1.rvalid !== 1'b1) $display("FAIL bp_s1_rvalid_held[%0d] got=%b want=1", i, s1.rvalid); else passed++;
      checks++; if (m.rready !== 1'b0) $display("FAIL bp_m_rready_held[%0d] got=%b want=0", i, m.rready); else passed++;
      tick();
    end
    s1.rready = 1;
    #1;
    checks++; if (m.rready !== 1'b1) $display("FAIL bp_m_rready_release got=%b want=1", m.rready); else passed++;
    checks++; if (s1.rdata !== 32'h6) $display("FAIL bp_s1_rdata got=%h want=6", s1.rdata); else passed++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_push_pop_full();
    bit own [4];
    own[0] = 1; own[1] = 0; own[2] = 1; own[3] = 1;
    do_reset();
    m.arready = 1; s0.arvalid = 1; s0.araddr = 32'hA0; s1.arvalid = 1; s1.araddr = 32'hB0;
    repeat (4) tick();
    s0.arvalid = 0; s1.araddr = 32'h300;
    m.rvalid = 1; m.rdata = 32'h11; s0.rready = 1; s1.rready = 1;
    #1;
    checks++; if (s1.arready !== 1'b1) $display("FAIL pp_s1_arready got=%b want=1", s1.arready); else passed++;
    checks++; if (s0.rvalid !== 1'b1) $display("FAIL pp_s0_rvalid got=%b want=1", s0.rvalid); else passed++;
    tick();
    s1.arvalid = 0; s0.arvalid = 1; m.rvalid = 0;
    #1;
    checks++; if (m.araddr !== 32'h300) $display("FAIL pp_m_araddr got=%h want=300", m.araddr); else passed++;
    checks++; if (s0.arready !== 1'b0) $display("FAIL pp_still_full got=%b want=0", s0.arready); else passed++;
    s0.arvalid = 0; m.rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (s1.rvalid !== own[i]) $display("FAIL pp_order_s1[%0d] got=%b want=%b", i, s1.rvalid, own[i]); else passed++;
      checks++; if (s0.rvalid !== !own[i]) $display("FAIL pp_order_s0[%0d] got=%b want=%b", i, s0.rvalid, !own[i]); else passed++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    m.arready = 1; s0.arvalid = 1; s0.araddr = 32'h20; s1.arvalid = 1; s1.araddr = 32'h30;
    repeat (3) tick();
    s0.arvalid = 0; s1.arvalid = 0;
    m.rvalid = 1; m.rdata = 32'hDEAD; s0.rready = 1; s1.rready = 1;
    areset = 1;
    #1;
    model_reset();
    checks++; if (m.arvalid !== 1'b0) $display("FAIL mid_rst_m_arvalid got=%b want=0", m.arvalid); else passed++;
    checks++; if (s0.rvalid !== 1'b0) $display("FAIL mid_rst_s0_rvalid got=%b want=0", s0.rvalid); else passed++;
    checks++; if (s1.rvalid !== 1'b0) $display("FAIL mid_rst_s1_rvalid got=%b want=0", s1.rvalid); else passed++;
    @(negedge aclk);
    areset = 0;
    #1;
    checks++; if ((s0.rvalid | s1.rvalid) !== 1'b0) $display("FAIL mid_rst_stale_r got=%b want=0", s0.rvalid | s1.rvalid); else passed++;
    m.rvalid = 0;
    s1.arvalid = 1; s1.araddr = 32'h40;
    #1;
    checks++; if (s1.arready !== 1'b1) $display("FAIL mid_rst_s1_arready got=%b want=1", s1.arready); else passed++;
    tick();
    s1.arvalid = 0;
    #1;
    checks++; if (m.araddr !== 32'h40) $display("FAIL mid_rst_m_araddr got=%h want=40", m.araddr); else passed++;
    tick();
    m.rvalid = 1; m.rdata = 32'hCAFE_0040;
    #1;
    checks++; if (s1.rvalid !== 1'b1) $display("FAIL mid_rst_s1_rvalid_new got=%b want=1", s1.rvalid); else passed++;
    checks++; if (s0.rvalid !== 1'b0) $display("FAIL mid_rst_s0_rvalid_new got=%b want=0", s0.rvalid); else passed++;
    checks++; if (s1.rdata !== 32'hCAFE_0040) $display("FAIL mid_rst_s1_rdata got=%h want=cafe0040", s1.rdata); else passed++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s0.arvalid = 1'($urandom_range(0, 1));
      s1.arvalid = 1'($urandom_range(0, 1));
      s0.araddr  = $urandom();
      s1.araddr  = $urandom();
      s0.arprot  = 3'($urandom_range(0, 7));
      s1.arprot  = 3'($urandom_range(0, 7));
      s0.rready  = ($urandom_range(0, 3) != 0);
      s1.rready  = ($urandom_range(0, 3) != 0);
      m.arready  = ($urandom_range(0, 3) != 0);
      m.rvalid   = (pending > 0) && ($urandom_range(0, 2) != 0);
      m.rdata    = $urandom();
      m.rresp    = 2'($urandom_range(0, 3));
      #1;
      model_comb();
      checks++; if (s0.arready !== exp_s0ar) $display("FAIL rnd_s0_arready[%0d] got=%b want=%b", i, s0.arready, exp_s0ar); else passed++;
      checks++; if (s1.arready !== exp_s1ar) $display("FAIL rnd_s1_arready[%0d] got=%b want=%b", i, s1.arready, exp_s1ar); else passed++;
      checks++; if (s0.rvalid !== exp_s0rv) $display("FAIL rnd_s0_rvalid[%0d] got=%b want=%b", i, s0.rvalid, exp_s0rv); else passed++;
      checks++; if (s1.rvalid !== exp_s1rv) $display("FAIL rnd_s1_rvalid[%0d] got=%b want=%b", i, s1.rvalid, exp_s1rv); else passed++;
      checks++; if (m.rready !== exp_mrr) $display("FAIL rnd_m_rready[%0d] got=%b want=%b", i, m.rready, exp_mrr); else passed++;
      checks++; if (m.arvalid !== exp_mv) $display("FAIL rnd_m_arvalid[%0d] got=%b want=%b", i, m.arvalid, exp_mv); else passed++;
      checks++; if (m.araddr !== exp_ma) $display("FAIL rnd_m_araddr[%0d] got=%h want=%h", i, m.araddr, exp_ma); else passed++;
      checks++; if (m.arprot !== exp_mp) $display("FAIL rnd_m_arprot[%0d] got=%h want=%h", i, m.arprot, exp_mp); else passed++;
      checks++; if (s1.rdata !== m.rdata) $display("FAIL rnd_s1_rdata[%0d] got=%h want=%h", i, s1.rdata, m.rdata); else passed++;
      checks++; if (s0.rresp !== m.rresp) $display("FAIL rnd_s0_rresp[%0d] got=%h want=%h", i, s0.rresp, m.rresp); else passed++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_tie();
    test_outstanding_limit();
    test_backpressure();
    test_push_pop_full();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
